// File: rtl/lif_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_UPD  = 2'd2,
        ST_DONE = 2'd3
    } lif_state_e;

    localparam int WIDTH_DEFAULT  = 8;
    localparam int THRESH_DEFAULT = 127;

    // Index width, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lif_update.sv
// Shared leaky-integrate-and-fire datapath: halve the stored state, add the current,
// saturate, compare against the threshold and pick the value to write back.
module lif_update
    import lif_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] thr,
    output logic             fire,
    output logic [WIDTH-1:0] new_state
);

    logic [WIDTH:0]   sum_wide;
    logic [WIDTH-1:0] sum;

    always_comb begin
        sum_wide  = {1'b0, cur} + {1'b0, state >> 1};
        sum       = sum_wide[WIDTH] ? '1 : sum_wide[WIDTH-1:0];
        fire      = (sum >= thr);
        new_state = fire ? '0 : sum;
    end

endmodule

// File: rtl/lif_scheduler.sv
// Walks NUM_NEURONS virtual neurons through one shared LIF update per timestep.
// state | meaning
// IDLE  | waiting for step_start, fire accumulator cleared
// REQ   | requesting current for neuron idx, waiting on cur_valid
// UPD   | applying the update to neuron idx, spike if it fired
// DONE  | step complete, spike_vec published
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS    = 4,
    parameter int WIDTH          = lif_pkg::WIDTH_DEFAULT,
    parameter int THRESH_DEFAULT = lif_pkg::THRESH_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 step_start,
    output logic                                 cur_req,
    output logic [idx_width(NUM_NEURONS)-1:0]    cur_idx,
    input  logic                                 cur_valid,
    input  logic [WIDTH-1:0]                     cur_data,
    input  logic                                 thr_we,
    input  logic [WIDTH-1:0]                     thr_data,
    output logic                                 spike_valid,
    output logic [idx_width(NUM_NEURONS)-1:0]    spike_idx,
    output logic [NUM_NEURONS-1:0]               spike_vec,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overrun
);

    localparam int            IW       = idx_width(NUM_NEURONS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);

    lif_state_e             state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [WIDTH-1:0]       cur_q, cur_d;
    logic [WIDTH-1:0]       thr_q, thr_d;
    logic [NUM_NEURONS-1:0] acc_q, acc_d;
    logic [NUM_NEURONS-1:0] spike_vec_q, spike_vec_d;
    logic                   overrun_q, overrun_d;
    logic [WIDTH-1:0]       mem_q [NUM_NEURONS];
    logic [WIDTH-1:0]       mem_d [NUM_NEURONS];
    logic                   upd_fire;
    logic [WIDTH-1:0]       upd_state;

    // The update works only from registered operands, so a threshold written in
    // the REQ cycle already applies to the UPD that follows it.
    lif_update #(.WIDTH(WIDTH)) u_update (
        .cur       (cur_q),
        .state     (mem_q[idx_q]),
        .thr       (thr_q),
        .fire      (upd_fire),
        .new_state (upd_state)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cur_d       = cur_q;
        acc_d       = acc_q;
        spike_vec_d = spike_vec_q;
        mem_d       = mem_q;
        thr_d       = thr_we ? thr_data : thr_q;
        overrun_d   = step_start && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                idx_d = '0;
                if (step_start) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (cur_valid) begin
                    cur_d   = cur_data;
                    state_d = ST_UPD;
                end
            end
            ST_UPD: begin
                mem_d[idx_q] = upd_state;
                if (upd_fire) acc_d[idx_q] = 1'b1;
                if (idx_q == LAST_IDX) begin
                    spike_vec_d = acc_d;
                    state_d     = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cur_q       <= '0;
            thr_q       <= WIDTH'(THRESH_DEFAULT);
            acc_q       <= '0;
            spike_vec_q <= '0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cur_q       <= cur_d;
            thr_q       <= thr_d;
            acc_q       <= acc_d;
            spike_vec_q <= spike_vec_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < NUM_NEURONS; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign cur_req     = (state_q == ST_REQ);
    assign cur_idx     = idx_q;
    assign spike_valid = (state_q == ST_UPD) && upd_fire;
    assign spike_idx   = spike_valid ? idx_q : '0;
    assign spike_vec   = spike_vec_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign overrun     = overrun_q;

endmodule
